// File: rtl/sha256_pkg.sv
// Shared constants and state type for the SHA-256 padding/loading front end.
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int DIGEST_W    = 256;
  localparam int LEN_FIELD_W = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  // Loader control states, visible on the debug port of the top.
  typedef enum logic [2:0] {
    ST_FILL     = 3'd0,
    ST_PAD      = 3'd1,
    ST_EMIT     = 3'd2,
    ST_WAIT_DIG = 3'd3,
    ST_SHIFT    = 3'd4
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_loader_if.sv
// Bundle of the message, block, digest and digest-beat streams around the loader.
//
// Handshake rule for every valid/ready pair here: a beat transfers on a rising
// clock edge where valid and ready are both high. Once valid is raised, the
// sender keeps valid and its payload unchanged until that transfer happens.
// Valid never waits for ready. dig_valid is the exception: it is a one-cycle
// pulse with no ready.
interface sha256_pad_loader_if
  import sha256_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) ();

  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic                in_last;

  logic                blk_valid;
  logic                blk_ready;
  logic [BLOCK_W-1:0]  blk_data;
  logic                blk_first;
  logic                blk_last;

  logic                dig_valid;
  logic [DIGEST_W-1:0] dig_in;

  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_last;

  logic                busy;

  // The loader itself.
  modport master (
    input  in_valid, in_data, in_last, blk_ready, dig_valid, dig_in, out_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last,
           out_valid, out_data, out_last, busy
  );

  // The surroundings: message source, compression core and digest sink.
  modport slave (
    output in_valid, in_data, in_last, blk_ready, dig_valid, dig_in, out_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last,
           out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/sha256_digest_serializer.sv
// Parallel-in / serial-out register returning the 256-bit digest MSB-first in
// OUT_W beats over a valid/ready stream.
module sha256_digest_serializer
  import sha256_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DIGEST_W-1:0] load_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_last,
  output logic                done
);

  localparam int BEATS = DIGEST_W / OUT_W;
  localparam int CW    = $clog2(BEATS + 1);

  logic [DIGEST_W-1:0] shreg;
  logic [CW-1:0]       beat_cnt;
  logic                fire;

  assign fire     = out_valid && out_ready;
  assign out_data = shreg[DIGEST_W-1 -: OUT_W];
  assign done     = fire && out_last;

  // Load on request; afterwards each accepted beat shifts the next one up.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      shreg     <= load_data;
      beat_cnt  <= '0;
      out_valid <= 1'b1;
      out_last  <= (BEATS == 1);
    end else if (fire) begin
      shreg    <= shreg << OUT_W;
      beat_cnt <= beat_cnt + 1'b1;
      if (out_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        out_last <= (beat_cnt == CW'(BEATS - 2));
      end
    end
  end

endmodule

// File: rtl/sha256_pad_loader.sv
// Collects message beats into 512-bit blocks and adds the 0x80 marker, the
// zero fill and the 64-bit bit-length. It hands blocks to the compression core
// and streams the returned digest back out.
module sha256_pad_loader
  import sha256_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int LEN_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  sha256_pad_loader_if.master bus,
  output pad_state_t         dbg_state
);

  localparam int N         = BLOCK_W / IN_W;                  // beats per block
  localparam int LEN_START = (BLOCK_W - LEN_FIELD_W) / IN_W;  // first length beat
  localparam int CNT_W     = $clog2(N + 1);
  localparam logic [IN_W-1:0] MARK_BEAT = IN_W'(PAD_BYTE) << (IN_W - 8);

  pad_state_t             state;
  logic [BLOCK_W-1:0]     blk_buf;
  logic [CNT_W-1:0]       cnt;
  logic [LEN_W-1:0]       len_q;
  logic                   blk_valid_q;
  logic                   blk_first_q;
  logic                   blk_last_q;
  logic                   first_arm;    // next block emitted starts a message
  logic                   pad_pending;  // after this block, go pad again
  logic                   mark_done;    // 0x80 marker already placed
  logic                   len_here;     // this block ends with the length field

  logic                   in_fire;
  logic                   blk_fire;
  logic                   dig_load;
  logic                   ser_done;
  logic [IN_W-1:0]        pad_beat;
  logic                   len_here_now;
  logic [LEN_FIELD_W-1:0] len_field;
  logic [LEN_FIELD_W-1:0] len_sh;

  assign in_fire   = bus.in_valid && (state == ST_FILL);
  assign blk_fire  = blk_valid_q && bus.blk_ready;
  assign dig_load  = bus.dig_valid && (state == ST_WAIT_DIG);
  assign len_field = LEN_FIELD_W'(len_q);

  assign bus.in_ready  = (state == ST_FILL);
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = blk_buf;
  assign bus.blk_first = blk_first_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.busy      = !((state == ST_FILL) && (cnt == '0));
  assign dbg_state     = state;

  // Next padding beat: marker first, then zeros, then the length MSB-first.
  // A marker at or beyond LEN_START leaves no room for the length field.
  always_comb begin
    pad_beat     = '0;
    len_here_now = len_here;
    len_sh       = len_field << (IN_W * int'(cnt - CNT_W'(LEN_START)));
    if (!mark_done) begin
      pad_beat     = MARK_BEAT;
      len_here_now = (cnt < CNT_W'(LEN_START));
    end else if (len_here && (cnt >= CNT_W'(LEN_START))) begin
      pad_beat = len_sh[LEN_FIELD_W-1 -: IN_W];
    end
  end

  // Control FSM with the buffer, counters and registered block outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FILL;
      blk_buf     <= '0;
      cnt         <= '0;
      len_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
      first_arm   <= 1'b1;
      pad_pending <= 1'b0;
      mark_done   <= 1'b0;
      len_here    <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (in_fire) begin
            blk_buf <= {blk_buf[BLOCK_W-IN_W-1:0], bus.in_data};
            cnt     <= cnt + 1'b1;
            len_q   <= len_q + LEN_W'(IN_W);
            if (cnt == CNT_W'(N - 1)) begin
              // Buffer full: ship it; a final beat here defers all padding.
              state       <= ST_EMIT;
              blk_valid_q <= 1'b1;
              blk_first_q <= first_arm;
              blk_last_q  <= 1'b0;
              pad_pending <= bus.in_last;
              mark_done   <= 1'b0;
            end else if (bus.in_last) begin
              state     <= ST_PAD;
              mark_done <= 1'b0;
            end
          end
        end

        ST_PAD: begin
          blk_buf   <= {blk_buf[BLOCK_W-IN_W-1:0], pad_beat};
          cnt       <= cnt + 1'b1;
          mark_done <= 1'b1;
          len_here  <= len_here_now;
          if (cnt == CNT_W'(N - 1)) begin
            state       <= ST_EMIT;
            blk_valid_q <= 1'b1;
            blk_first_q <= first_arm;
            blk_last_q  <= len_here_now;
            // No room for the length: one more zeros-plus-length block follows.
            pad_pending <= !len_here_now;
            if (!len_here_now) begin
              len_here <= 1'b1;
            end
          end
        end

        ST_EMIT: begin
          if (blk_fire) begin
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
            first_arm   <= 1'b0;
            cnt         <= '0;
            if (blk_last_q) begin
              state <= ST_WAIT_DIG;
            end else if (pad_pending) begin
              state       <= ST_PAD;
              pad_pending <= 1'b0;
            end else begin
              state <= ST_FILL;
            end
          end
        end

        ST_WAIT_DIG: begin
          if (bus.dig_valid) begin
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (ser_done) begin
            state     <= ST_FILL;
            len_q     <= '0;
            first_arm <= 1'b1;
          end
        end

        default: state <= ST_FILL;
      endcase
    end
  end

  sha256_digest_serializer #(
    .OUT_W(OUT_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (dig_load),
    .load_data(bus.dig_in),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (bus.out_data),
    .out_last (bus.out_last),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_sha256_pad_loader.sv
// Bench for sha256_pad_loader: byte messages in, blocks and digest beats
// compared against a FIPS 180-4 padding model built from byte queues.
module tb_sha256_pad_loader;
  import sha256_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int LEN_W = 32;
  localparam int NB    = BLOCK_W / 8;      // bytes per block
  localparam int BPB   = BLOCK_W / IN_W;   // beats per block
  localparam int OB    = DIGEST_W / OUT_W; // digest beats

  typedef logic [7:0] byte_q_t[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  pad_state_t dbg_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_pad_loader_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  sha256_pad_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [BLOCK_W-1:0] exp_blk_q[$];
  bit                 exp_bfirst_q[$];
  bit                 exp_blast_q[$];
  logic [OUT_W-1:0]   exp_q[$];
  bit                 exp_olast_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit stall_on = 1'b0;
  bit spur_req = 1'b0;
  int exp_rise = -1;
  int exp_orise = -1;
  int beats_in = 0;
  int dig_req = 0;
  logic [DIGEST_W-1:0] dig_next = '0;

  task automatic check(input string tag, input logic [BLOCK_W-1:0] got,
                       input logic [BLOCK_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DIGEST_W-1:0] rand256();
    logic [DIGEST_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGEST_W / 32; i++) r = {r[DIGEST_W-33:0], $urandom};
    return r;
  endfunction

  function automatic byte_q_t fill_msg(input int n, input logic [7:0] v);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(v);
    return q;
  endfunction

  // Reference: pad the byte string, append the 64-bit bit length, cut into blocks.
  task automatic model_msg(input byte_q_t msg);
    byte_q_t p;
    logic [63:0] bits;
    logic [BLOCK_W-1:0] blk;
    int nblk;
    p = msg;
    bits = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % NB != NB - 8) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(bits[63 - 8*i -: 8]);
    nblk = p.size() / NB;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < NB; j++) blk = {blk[BLOCK_W-9:0], p[b*NB + j]};
      exp_blk_q.push_back(blk);
      exp_bfirst_q.push_back(b == 0);
      exp_blast_q.push_back(b == nblk - 1);
    end
  endtask

  task automatic flush();
    exp_blk_q.delete();
    exp_bfirst_q.delete();
    exp_blast_q.delete();
    exp_q.delete();
    exp_olast_q.delete();
    exp_rise = -1;
    exp_orise = -1;
    beats_in = 0;
    dig_req = 0;
  endtask

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the beat transferred.
  task automatic send_beat(input logic [IN_W-1:0] d, input bit last);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int w = 0; w < 3000; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("in_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t msg);
    for (int i = 0; i < msg.size(); i++) begin
      send_beat(msg[i], i == msg.size() - 1);
      if (stall_on) repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 6000; w++) begin
      @(negedge clk);
      if (exp_blk_q.size() == 0 && exp_q.size() == 0 && dig_req == 0 &&
          !bus.out_valid && !bus.busy) break;
    end
    check("drain", exp_blk_q.size() + exp_q.size() + dig_req, 0);
  endtask

  task automatic run_msg(input byte_q_t msg);
    model_msg(msg);
    @(posedge clk);
    #1;
    send_msg(msg);
    wait_idle();
  endtask

  // Ready generators: always ready, or 50% random when stalling.
  initial begin
    bus.blk_ready = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.blk_ready = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Core model: answers each final block with one digest pulse after a delay.
  initial begin
    bus.dig_valid = 1'b0;
    bus.dig_in    = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.dig_valid = 1'b0;
      if (!rst && spur_req) begin
        bus.dig_valid = 1'b1;
        bus.dig_in    = rand256();
        spur_req      = 1'b0;
      end else if (!rst && dig_req > 0 && $urandom_range(0, 2) == 0) begin
        bus.dig_valid = 1'b1;
        bus.dig_in    = dig_next;
        dig_req--;
        for (int i = 0; i < OB; i++) begin
          exp_q.push_back(dig_next[DIGEST_W-1 - i*OUT_W -: OUT_W]);
          exp_olast_q.push_back(i == OB - 1);
        end
      end
    end
  end

  // ---------------- block monitor ----------------
  logic [BLOCK_W-1:0] pv_data;
  bit pv_valid = 1'b0, pv_ready = 1'b0, pv_first = 1'b0, pv_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pv_valid = 1'b0;
    end else begin
      if (bus.blk_valid && !pv_valid && exp_rise >= 0) begin
        check("blk_latency", cyc, exp_rise);
        exp_rise = -1;
      end
      if (bus.blk_valid && pv_valid && !pv_ready) begin
        check("blk_hold_data", bus.blk_data, pv_data);
        check("blk_hold_flags", {bus.blk_first, bus.blk_last}, {pv_first, pv_last});
      end
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_blk_q.size() == 0) begin
          check("blk_unexpected", 1, 0);
        end else begin
          check("blk_data", bus.blk_data, exp_blk_q.pop_front());
          check("blk_first", bus.blk_first, exp_bfirst_q.pop_front());
          if (exp_blast_q[0]) dig_req++;
          check("blk_last", bus.blk_last, exp_blast_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        beats_in++;
        if (beats_in % BPB == 0) exp_rise = cyc + 1;
        else if (bus.in_last) exp_rise = cyc + 1 + (BPB - beats_in % BPB);
        if (bus.in_last) beats_in = 0;
      end
      pv_valid = bus.blk_valid;
      pv_ready = bus.blk_ready;
      pv_data  = bus.blk_data;
      pv_first = bus.blk_first;
      pv_last  = bus.blk_last;
    end
  end

  // ---------------- digest beat monitor ----------------
  logic [OUT_W-1:0] po_data;
  bit po_valid = 1'b0, po_ready = 1'b0, po_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      po_valid = 1'b0;
    end else begin
      if (bus.out_valid && !po_valid && exp_orise >= 0) begin
        check("out_latency", cyc, exp_orise);
        exp_orise = -1;
      end
      if (bus.dig_valid) exp_orise = cyc + 1;
      if (bus.out_valid && po_valid && !po_ready) begin
        check("out_hold", {bus.out_data, bus.out_last}, {po_data, po_last});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
          check("out_last", bus.out_last, exp_olast_q.pop_front());
        end
      end
      po_valid = bus.out_valid;
      po_ready = bus.out_ready;
      po_data  = bus.out_data;
      po_last  = bus.out_last;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    byte_q_t abc;
    byte_q_t msg;
    int len;
    abc = '{8'h61, 8'h62, 8'h63};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_blk_valid", bus.blk_valid, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_blk_data", bus.blk_data, 0);
    check("rst_state", dbg_state, ST_FILL);

    // "abc" with the known SHA-256 digest returned by the core model.
    dig_next = 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
    run_msg(abc);

    // Padding boundaries.
    dig_next = rand256();
    run_msg(fill_msg(55, 8'h61));
    dig_next = rand256();
    run_msg(fill_msg(56, 8'h61));
    dig_next = rand256();
    run_msg(fill_msg(63, 8'h61));
    dig_next = rand256();
    run_msg(fill_msg(64, 8'h61));

    // Backpressure on both output streams.
    stall_on = 1'b1;
    dig_next = 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
    run_msg(abc);
    stall_on = 1'b0;

    // Reset in the 10th PAD cycle discards the message.
    @(posedge clk);
    #1;
    send_msg(abc);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_state", dbg_state, ST_PAD);
    rst = 1'b1;
    flush();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_blk_valid", bus.blk_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_blk_data", bus.blk_data, 0);
    dig_next = rand256();
    run_msg(abc);

    // A digest pulse while idle is ignored.
    spur_req = 1'b1;
    repeat (20) @(negedge clk);
    check("spur_out_valid", bus.out_valid, 0);
    check("spur_busy", bus.busy, 0);

    // Random messages, alternating stalls.
    for (int r = 0; r < 6; r++) begin
      stall_on = r[0];
      len = $urandom_range(1, 140);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      dig_next = rand256();
      run_msg(msg);
    end
    stall_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, failed so far %0d", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/sha256_pad_loader.md
# sha256_pad_loader

Parametrised successor to the byte-serial SHA-256 input shift register. It accepts message beats over a valid/ready stream and applies FIPS 180-4 padding and the 64-bit length field in hardware. It presents complete 512-bit blocks to the compression core and serialises the returned 256-bit digest back out over a narrow stream. It sits between the pad-level I/O and the `sha256` round engine.

## Interface
- `IN_W`, 8, input beat width in bits; legal values 8, 16, 32.
- `OUT_W`, 8, digest output beat width in bits; legal values 8, 16, 32.
- `LEN_W`, 32, message bit-length counter width; 64-bit length field bits above `LEN_W` are zero.
- `clk` in 1 — the only clock; all logic on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — input beat valid.
- `in_ready` out 1 — input beat accepted when `in_valid && in_ready`.
- `in_data` in IN_W — message beat; first byte in the MSBs.
- `in_last` in 1 — final beat of the message; only valid together with a data beat.
- `blk_valid` out 1 — `blk_data` holds a complete block.
- `blk_ready` in 1 — core accepts the block.
- `blk_data` out 512 — block, big-endian; the first message byte is in `[511:504]`.
- `blk_first` out 1 — block is the first of its message (core reloads H0).
- `blk_last` out 1 — block is the final block of its message.
- `dig_valid` in 1 — single-cycle pulse from the core; digest is valid.
- `dig_in` in 256 — digest H0..H7, H0 in the MSBs.
- `out_valid` out 1 — digest beat valid.
- `out_ready` in 1 — digest beat accepted.
- `out_data` out OUT_W — digest beat, MSB-first.
- `out_last` out 1 — final digest beat.
- `busy` out 1 — high in every state except FILL with an empty buffer.

## Operation
- **States:** FILL, PAD, EMIT, WAIT_DIG, SHIFT.
- **Reset values:** all outputs 0, except `in_ready` = 1; buffer count 0; length counter 0; state FILL.
- **FILL**
  - `in_ready` = 1.
  - Each accepted beat shifts into the 512-bit buffer.
  - Count increments by 1; length counter increments by `IN_W`, wrapping mod 2^LEN_W.
  - At 512/IN_W beats without `in_last`: go to EMIT with `blk_last` = 0.
  - On `in_last`:
    - Buffer full → EMIT with a pending-pad flag set.
    - Otherwise → PAD.
- **PAD**
  - `in_ready` = 0. Inserts one IN_W beat per cycle.
  - First pad beat: 0x80 in the top byte, zeros below.
  - Then zero beats until count = 448/IN_W.
  - Then 64/IN_W length beats, MSB-first.
  - If the count after the 0x80 beat exceeds 448/IN_W: zero-fill to 512, go to EMIT with `blk_last` = 0, then return to PAD for a zeros-plus-length block.
  - Pending-pad block (entered after a full-buffer `in_last`): 0x80 beat, zeros, length.
- **EMIT**
  - `blk_valid` = 1; `blk_data`, `blk_first` and `blk_last` are held stable until `blk_ready`.
  - On handshake: count → 0, then:
    - `blk_last` = 1 → WAIT_DIG.
    - Pending padding → PAD.
    - Otherwise → FILL.
  - `blk_first` = 1 only on the first block after reset or after a completed digest.
- **WAIT_DIG:** waits for the `dig_valid` pulse, captures `dig_in`, goes to SHIFT. Pulses in any other state are ignored.
- **SHIFT**
  - 256/OUT_W beats with MSB-first; each handshake shifts by OUT_W.
  - `out_last` is asserted on the final beat.
  - After the final handshake → FILL; length counter is cleared and `blk_first` is re-armed.
- Zero-length messages are unsupported (no beat can carry `in_last` without data).

## Timing
- Registered outputs; no combinational path from any input to any output except `in_ready` (state-derived only).
- Full block with no `in_last`: accepted in cycle t → `blk_valid` high in cycle t+1.
- Padding block: `in_last` accepted in cycle t with k beats buffered → `blk_valid` high in cycle t+1+(512/IN_W − k).
- Backpressure:
  - `blk_ready` low holds EMIT indefinitely, with data stable.
  - `out_ready` low holds the current digest beat.
- Digest: `dig_valid` in cycle d → `out_valid` high in cycle d+1.
- Reset mid-operation (any state): next cycle all outputs at reset values, buffer, count and length cleared; an in-flight block or digest is discarded.

## Structure
- Shared package `sha256_pkg`:
  - `BLOCK_W` = 512, `DIGEST_W` = 256, `LEN_FIELD_W` = 64, `PAD_BYTE` = 8'h80.
  - State enum `pad_state_t`.
- One sub-module, `sha256_digest_serializer`: a 256-bit parallel-in/serial-out register with a valid/ready handshake, parametrised on `OUT_W`. It implements SHIFT.

## Test plan
- "abc", IN_W = 8, blk_ready = 1 → in_last in cycle 2, one block `0x61626380_00…00_00000018` at cycle 64, blk_first = blk_last = 1; dig_in = BA7816BF…F20015AD → 32 out beats 0xBA, 0x78, …, 0xAD, out_last on the last.
- 55 bytes of 0x61 → single block, byte 55 = 0x80, length 0x1B8.
- 56 bytes of 0x61 → two blocks: the first ends 0x80 followed by zeros with blk_last = 0; the second is all zeros with length 0x1C0 and blk_last = 1.
- 64 bytes, IN_W = 32 → first block raw, blk_last = 0; second block 0x80000000 then zeros and length 0x200.
- Random blk_ready/out_ready stalls (50%) on "abc" → identical block and digest beats, data stable during stalls.
- rst asserted in the 10th PAD cycle → next cycle blk_valid = 0, in_ready = 1, busy = 0; a following "abc" yields the same block as the first scenario.
